// File: rtl/rs5_reset_sequencer.sv
// rs5_reset_sequencer
//
// Reset controller for the RS5 core. Converts the asynchronous active-low
// board reset into a registered active-high core reset that is held for
// HOLD_CYCLES cycles after release. Run-time reset requests from debug,
// software and an optional watchdog are arbitrated with fixed priority
// DBG > WDT > SW. The source of the most recent reset is recorded.
//
// Optional feature macro: RS5_RESET_WDT_EN
//   defined   : watchdog counter and WDT reset cause are built in
//   undefined : watchdog ports are accepted but ignored, cause 11 never occurs
//
// Parameters:
//   HOLD_CYCLES   cycles rst_cpu_o stays high after release/request (1..255)
//   WDT_WIDTH     width of the watchdog counter and limit
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   sw_rst_req_i   software reset request, sampled every edge
//   dbg_rst_req_i  debug reset request, level; holds the core in reset
//   wdt_en_i       watchdog enable
//   wdt_kick_i     watchdog service, clears the counter
//   wdt_limit_i    watchdog timeout in cycles, 0 disables
//   rst_cpu_o      active-high core reset (registered)
//   rst_cause_o    last reset source: 00 POR, 01 SW, 10 DBG, 11 WDT
//   rst_count_o    number of non-POR resets, saturating at 255
//   busy_o         high whenever the sequencer is not in RUN

module rs5_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned WDT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sw_rst_req_i,
  input  logic                 dbg_rst_req_i,
  input  logic                 wdt_en_i,
  input  logic                 wdt_kick_i,
  input  logic [WDT_WIDTH-1:0] wdt_limit_i,
  output logic                 rst_cpu_o,
  output logic [1:0]           rst_cause_o,
  output logic [7:0]           rst_count_o,
  output logic                 busy_o
);

  typedef enum logic {
    StHold = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [7:0] HoldLast  = 8'(HOLD_CYCLES - 1);
  localparam logic [1:0] CausePor  = 2'b00;
  localparam logic [1:0] CauseSw   = 2'b01;
  localparam logic [1:0] CauseDbg  = 2'b10;
  localparam logic [1:0] CauseWdt  = 2'b11;

  logic [1:0] sync_q;
  logic       rel;
  state_e     state_q, state_d;
  logic [7:0] holdCnt_q, holdCnt_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] count_q, count_d;
  logic       rstCpu_q, rstCpu_d;
  logic       wdtFire;

  // Two-flop release synchroniser: cleared asynchronously by the pin, then
  // shifts in ones so the release reaches the core logic two edges later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rel = sync_q[1];

`ifdef RS5_RESET_WDT_EN
  logic [WDT_WIDTH-1:0] wdtCnt_q, wdtCnt_d;
  logic                 wdtActive;

  // Watchdog timeout detection. A >= compare lets a limit lowered below the
  // running count fire on the next unkicked edge; a kick always wins.
  always_comb begin
    wdtActive = (state_q == StRun) && wdt_en_i && (wdt_limit_i != '0);
    wdtFire   = wdtActive && !wdt_kick_i && (wdtCnt_q >= wdt_limit_i);
  end

  // Watchdog counter next value: cleared whenever it is not counting, on a
  // kick, and on the edge that takes the sequencer back into HOLD.
  always_comb begin
    wdtCnt_d = wdtCnt_q;
    if (!wdtActive || (state_d != StRun) || wdt_kick_i) begin
      wdtCnt_d = '0;
    end else begin
      wdtCnt_d = wdtCnt_q + {{(WDT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdtCnt_q <= '0;
    end else begin
      wdtCnt_q <= wdtCnt_d;
    end
  end
`else
  logic unusedWdtInputs;

  // Without the watchdog the related inputs are deliberately left unused.
  assign unusedWdtInputs = ^{wdt_en_i, wdt_kick_i, wdt_limit_i};
  assign wdtFire         = 1'b0;
`endif

  // Sequencer next state. HOLD counts cycles once the release is
  // synchronised and debug is not asserting; RUN arbitrates the requesters
  // and records the winning cause. Lower-priority requests are ignored in HOLD.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    cause_d   = cause_q;
    count_d   = count_q;
    unique case (state_q)
      StHold: begin
        if (!rel || dbg_rst_req_i) begin
          holdCnt_d = 8'd0;
        end else if (holdCnt_q == HoldLast) begin
          state_d   = StRun;
          holdCnt_d = 8'd0;
        end else begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
      end
      StRun: begin
        if (dbg_rst_req_i || wdtFire || sw_rst_req_i) begin
          state_d   = StHold;
          holdCnt_d = 8'd0;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          if (dbg_rst_req_i) begin
            cause_d = CauseDbg;
          end else if (wdtFire) begin
            cause_d = CauseWdt;
          end else begin
            cause_d = CauseSw;
          end
        end
      end
      default: begin
        state_d   = StHold;
        holdCnt_d = 8'd0;
      end
    endcase
    rstCpu_d = (state_d == StHold);
  end

  // State, counters and the registered core reset. The pin reset puts
  // everything back to the power-on condition from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StHold;
      holdCnt_q <= 8'd0;
      cause_q   <= CausePor;
      count_q   <= 8'd0;
      rstCpu_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
      rstCpu_q  <= rstCpu_d;
    end
  end

  assign rst_cpu_o   = rstCpu_q;
  assign busy_o      = rstCpu_q;
  assign rst_cause_o = cause_q;
  assign rst_count_o = count_q;

endmodule

// File: doc/rs5_reset_sequencer.md
# rs5_reset_sequencer

Reset controller for the RS5 core. It takes the asynchronous active-low board/bench reset and produces the core's active-high reset, held for a fixed number of cycles after release. It also arbitrates three run-time reset requesters: debug, software and an optional watchdog. It records which source caused the last reset. It sits between the top-level reset pin and the `rst_i` input of the core/testbench.

## Interface
- `HOLD_CYCLES`, default 10: cycles `rst_cpu_o` stays high after the synchronised release or a request; 10 cycles is 100 ns at 10 ns clock; legal range 1..255.
- `WDT_WIDTH`, default 16: width of the watchdog counter and limit.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: **asynchronous, active-low** reset.
- `sw_rst_req_i` in 1: software reset request, sampled on each edge.
- `dbg_rst_req_i` in 1: debug reset request; level, holds the core in reset while high.
- `wdt_en_i` in 1: watchdog enable.
- `wdt_kick_i` in 1: watchdog service; clears the counter.
- `wdt_limit_i` in WDT_WIDTH: watchdog timeout in cycles; 0 disables the watchdog.
- `rst_cpu_o` out 1: active-high core reset, registered.
- `rst_cause_o` out 2: last reset source: 00 POR, 01 SW, 10 DBG, 11 WDT.
- `rst_count_o` out 8: number of non-POR resets, saturating.
- `busy_o` out 1: high whenever the FSM is not in RUN.

## Operation
- Reset synchroniser: 2-flop chain, async-cleared by `rst_ni`, shifts in 1. Its output is the internal release `rel`.
- FSM states:
  - HOLD: `rst_cpu_o`=1; 8-bit `hold_cnt` counts.
  - RUN: `rst_cpu_o`=0.
- rst_ni low, asynchronously:
  - state=HOLD, `hold_cnt`=0, synchroniser=00, watchdog counter=0.
  - `rst_cpu_o`=1, `rst_cause_o`=00, `rst_count_o`=0, `busy_o`=1.
  - This applies mid-operation, in any state.
- HOLD:
  - While `rel`=0 or `dbg_rst_req_i`=1, `hold_cnt` is held at 0.
  - Otherwise it increments by 1 per cycle.
  - On the edge where `hold_cnt`==HOLD_CYCLES-1 (and the increment condition holds), go to RUN.
  - `sw_rst_req_i` and the watchdog are ignored in HOLD.
- RUN: requests are sampled each edge with fixed priority DBG > WDT > SW.
  - On a request, go to HOLD with `hold_cnt`=0.
  - `rst_cause_o` is set to the winning source.
  - `rst_count_o` increments if it is below 255.
  - Simultaneous requests record only the highest-priority cause.
- Watchdog:
  - Counts only in RUN with `wdt_en_i`=1 and `wdt_limit_i`!=0; kick has priority over the increment.
  - Timeout fires when the count equals `wdt_limit_i` on an edge where no kick is present.
  - The counter clears on entering HOLD and whenever `wdt_en_i`=0.
  - The count does not wrap: it reaches the limit first. A limit lowered below the current count fires on the next non-kicked edge, using a ≥ compare.

## Timing
- POR: with `rst_ni` rising before edge 0:
  - `rel`=1 after edge 1.
  - `rst_cpu_o` falls after edge HOLD_CYCLES+1, i.e. HOLD_CYCLES+2 edges in total.
- Run-time request sampled at edge k:
  - `rst_cpu_o`=1 and the cause/count updated after edge k.
  - `rst_cpu_o`=0 after edge k+HOLD_CYCLES, if DBG is not held.
- DBG held through edge m: release follows at edge m+HOLD_CYCLES.
- Watchdog, limit L, enabled with no kicks from RUN entry at edge r: reset asserted after edge r+L+1.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- `RS5_RESET_WDT_EN` defined: watchdog counter and WDT cause are compiled in.
- Undefined: no watchdog counter is instantiated.
  - `wdt_en_i`, `wdt_kick_i` and `wdt_limit_i` remain as ports but are ignored.
  - Cause 11 is never produced.

## Test plan
- POR, HOLD_CYCLES=10: release `rst_ni` before edge 0 → `rst_cpu_o`=1 through edge 11, 0 after it; cause=00, count=0.
- SW pulse, 1 cycle, in RUN at edge 50 → `rst_cpu_o` high after edge 50, low after edge 60; cause=01, count=1.
- DBG and SW high together at edge 40, DBG held to edge 70 → cause=10, count=1; `rst_cpu_o` low after edge 80; SW ignored in HOLD.
- WDT (macro on), limit=20, enabled, kick every 15 cycles → no reset. Stop kicking → reset 21 cycles after the last kick-cleared count; cause=11.
- `rst_ni` pulsed low mid-HOLD after a SW reset → immediate `rst_cpu_o`=1; cause=00, count=0; full POR sequence restarts.
- 300 SW resets → `rst_count_o` saturates at 255. With the macro off, WDT stimulus never resets.
